// File: rtl/life_pkg.sv
// Shared types and constants for the life_engine cellular automaton.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package life_pkg;

   typedef enum logic [1:0] {
      OP_STEP  = 2'd0,
      OP_RAND  = 2'd1,
      OP_CLEAR = 2'd2,
      OP_NOP   = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UPDATE,
      ST_COPY,
      ST_FILL,
      ST_FINISH
   } state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam int LFSR_TAP_A = 15;
   localparam int LFSR_TAP_B = 13;
   localparam int LFSR_TAP_C = 12;
   localparam int LFSR_TAP_D = 10;

   // Neighbour visiting order, indexed by the read phase 0..7.
   localparam logic signed [1:0] NB_DX [8] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
   localparam logic signed [1:0] NB_DY [8] = '{ 2'sd1, 2'sd1, 2'sd1,  2'sd0, 2'sd0, -2'sd1, -2'sd1, -2'sd1};

   // Classic Conway rule: born on 3, survive on 2 or 3.
   localparam logic [8:0] RULE_B3  = 9'b000001000;
   localparam logic [8:0] RULE_S23 = 9'b000001100;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
   endfunction

endpackage

// File: rtl/life_engine_if.sv
// Command, status and display-read bundle between controller and life_engine.
// Latency: n/a (wires only).
// Backpressure: cmd_valid is held by the master until cmd_ready is seen high.
interface life_engine_if #(
   parameter int LOG_W = 6,
   parameter int LOG_H = 5,
   parameter int GEN_W = 16
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [1:0]             cmd_op;
   logic [8:0]             birth_mask;
   logic [8:0]             survive_mask;
   logic                   busy;
   logic                   done;
   logic [LOG_W-1:0]       rd_x;
   logic [LOG_H-1:0]       rd_y;
   logic                   rd_cell;
   logic [GEN_W-1:0]       generation;
   logic [LOG_W+LOG_H:0]   population;

   modport master (
      output cmd_valid, cmd_op, birth_mask, survive_mask, rd_x, rd_y,
      input  cmd_ready, busy, done, rd_cell, generation, population
   );

   modport slave (
      input  cmd_valid, cmd_op, birth_mask, survive_mask, rd_x, rd_y,
      output cmd_ready, busy, done, rd_cell, generation, population
   );
endinterface

// File: rtl/life_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR supplying random cell values.
// Latency: new bit every cycle, seeded on reset.
// Backpressure: none, never stalls.
module life_lfsr16
   import life_pkg::*;
(
   input  logic clk,
   input  logic reset,
   output logic o_bit
);
   logic [15:0] r_lfsr;

   // Shift every cycle, including while the engine is idle.
   always_ff @(posedge clk) begin
      if (reset) r_lfsr <= LFSR_SEED;
      else       r_lfsr <= lfsr_next(r_lfsr);
   end

   assign o_bit = r_lfsr[0];
endmodule

// File: rtl/life_engine.sv
// Cellular automaton engine: STEP / RANDOMIZE / CLEAR / NOP on a 2^LOG_W x 2^LOG_H board.
// Latency: STEP done after 10N edges, RANDOMIZE/CLEAR after N, NOP after 1 (N = cell count).
// Backpressure: cmd_ready only in IDLE; cmd_valid ignored while busy. Macro LIFE_TORUS_EN wraps edges.
module life_engine
   import life_pkg::*;
#(
   parameter int LOG_W = 6,
   parameter int LOG_H = 5,
   parameter int GEN_W = 16
)(
   input  logic          clk,
   input  logic          reset,
   life_engine_if.slave  bus
);
   localparam int AW = LOG_W + LOG_H;
   localparam int PW = AW + 1;
   localparam int N  = 1 << AW;

   state_e            r_state;
   op_e               r_op;
   logic [8:0]        r_birth;
   logic [8:0]        r_survive;
   logic [AW-1:0]     r_idx;
   logic [3:0]        r_phase;
   logic [3:0]        r_cnt;
   logic [PW-1:0]     r_pop_acc;
   logic [PW-1:0]     r_pop;
   logic [GEN_W-1:0]  r_gen;
   logic              r_busy;
   logic              r_done;
   logic [N-1:0]      r_board;
   logic [N-1:0]      r_next;

   logic              w_lfsr_bit;
   logic [LOG_W-1:0]  w_x;
   logic [LOG_H-1:0]  w_y;
   logic signed [1:0] w_dx;
   logic signed [1:0] w_dy;
   logic [LOG_W+1:0]  w_nx;
   logic [LOG_H+1:0]  w_ny;
   logic              w_nbr;
   logic              w_rule;
   logic              w_wr_bit;
   logic              w_fill_last;

   life_lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .o_bit (w_lfsr_bit)
   );

   // Neighbour coordinate: two guard bits catch -1 and W (or H) for the border test.
   assign w_x  = r_idx[LOG_W-1:0];
   assign w_y  = r_idx[AW-1:LOG_W];
   assign w_dx = NB_DX[r_phase[2:0]];
   assign w_dy = NB_DY[r_phase[2:0]];
   assign w_nx = {2'b00, w_x} + {{LOG_W{w_dx[1]}}, w_dx};
   assign w_ny = {2'b00, w_y} + {{LOG_H{w_dy[1]}}, w_dy};

`ifdef LIFE_TORUS_EN
   // Low coordinate bits already wrap modulo the board size.
   assign w_nbr = r_board[{w_ny[LOG_H-1:0], w_nx[LOG_W-1:0]}];
`else
   logic w_in_board;
   assign w_in_board = (w_nx[LOG_W+1:LOG_W] == 2'b00) && (w_ny[LOG_H+1:LOG_H] == 2'b00);
   assign w_nbr      = w_in_board & r_board[{w_ny[LOG_H-1:0], w_nx[LOG_W-1:0]}];
`endif

   assign w_rule      = r_board[r_idx] ? r_survive[r_cnt] : r_birth[r_cnt];
   assign w_wr_bit    = (r_state == ST_COPY) ? r_next[r_idx]
                      : ((r_op == OP_RAND) ? w_lfsr_bit : 1'b0);
   assign w_fill_last = (r_idx == {AW{1'b1}});

   // Command sequencer: 9-cycle per-cell update, then linear copy/fill, then one FINISH cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_op      <= OP_NOP;
         r_birth   <= RULE_B3;
         r_survive <= RULE_S23;
         r_idx     <= '0;
         r_phase   <= '0;
         r_cnt     <= '0;
         r_pop_acc <= '0;
         r_pop     <= '0;
         r_gen     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  r_op      <= op_e'(bus.cmd_op);
                  r_birth   <= bus.birth_mask;
                  r_survive <= bus.survive_mask;
                  r_idx     <= '0;
                  r_phase   <= '0;
                  r_cnt     <= '0;
                  r_pop_acc <= '0;
                  r_busy    <= 1'b1;
                  // NOP borrows FILL for one cycle so done lands one edge after acceptance.
                  r_state   <= (op_e'(bus.cmd_op) == OP_STEP) ? ST_UPDATE : ST_FILL;
               end
            end
            ST_UPDATE: begin
               if (r_phase == 4'd8) begin
                  r_phase <= '0;
                  r_cnt   <= '0;
                  r_idx   <= r_idx + 1'b1;
                  if (w_fill_last) r_state <= ST_COPY;
               end else begin
                  r_phase <= r_phase + 1'b1;
                  r_cnt   <= r_cnt + {3'b000, w_nbr};
               end
            end
            ST_COPY, ST_FILL: begin
               if (r_state == ST_FILL && r_op == OP_NOP) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_FINISH;
               end else begin
                  r_pop_acc <= r_pop_acc + {{AW{1'b0}}, w_wr_bit};
                  r_idx     <= r_idx + 1'b1;
                  if (w_fill_last) begin
                     r_pop   <= r_pop_acc + {{AW{1'b0}}, w_wr_bit};
                     r_gen   <= (r_state == ST_COPY) ? r_gen + 1'b1 : '0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_FINISH;
                  end
               end
            end
            ST_FINISH: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Board and shadow writes; no reset so contents survive an aborted command.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == ST_UPDATE && r_phase == 4'd8)
            r_next[r_idx] <= w_rule;
         if (r_state == ST_COPY || (r_state == ST_FILL && r_op != OP_NOP))
            r_board[r_idx] <= w_wr_bit;
      end
   end

   assign bus.cmd_ready  = (r_state == ST_IDLE);
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.generation = r_gen;
   assign bus.population = r_pop;
   assign bus.rd_cell    = r_board[{bus.rd_y, bus.rd_x}];
endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine on a 32x16 board.
// Latency: expects done 10N / N / 1 edges after the accepting edge.
// Backpressure: drives cmd_valid until accepted; one command in flight at a time.
module tb_life_engine;
   import life_pkg::*;

   localparam int LW = 5;
   localparam int LH = 4;
   localparam int GW = 16;
   localparam int W  = 1 << LW;
   localparam int H  = 1 << LH;
   localparam int N  = W * H;
   localparam int PW = LW + LH + 1;

   typedef struct {
      logic [GW-1:0] gen;
      logic [PW-1:0] pop;
      int            lat;
      logic [N-1:0]  board;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc   = 0;
   int   n_acc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   logic [15:0]   m_lfsr;
   logic [N-1:0]  m_board;
   logic [GW-1:0] m_gen;
   logic [PW-1:0] m_pop;
   exp_t          sb_q[$];

   life_engine_if #(.LOG_W(LW), .LOG_H(LH), .GEN_W(GW)) bus ();

   life_engine #(.LOG_W(LW), .LOG_H(LH), .GEN_W(GW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Cycle count, accepted-command count and the reference LFSR.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && bus.cmd_valid && bus.cmd_ready) n_acc <= n_acc + 1;
      if (reset) m_lfsr <= 16'hACE1;
      else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, wanted completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   function automatic logic [N-1:0] life_step(input logic [N-1:0] b, input logic [8:0] bm,
                                              input logic [8:0] sm);
      logic [N-1:0] nb;
      nb = '0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            int n;
            n = 0;
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  int xx;
                  int yy;
                  if (dx == 0 && dy == 0) continue;
                  xx = x + dx;
                  yy = y + dy;
`ifdef LIFE_TORUS_EN
                  xx = (xx + W) % W;
                  yy = (yy + H) % H;
`else
                  if (xx < 0 || xx >= W || yy < 0 || yy >= H) continue;
`endif
                  if (b[yy*W + xx]) n++;
               end
            end
            nb[y*W + x] = b[y*W + x] ? sm[n] : bm[n];
         end
      end
      return nb;
   endfunction

   task automatic read_row(input int y, output logic [W-1:0] r);
      r = '0;
      bus.rd_y = LH'(y);
      for (int x = 0; x < W; x++) begin
         bus.rd_x = LW'(x);
         #1;
         r[x] = bus.rd_cell;
      end
   endtask

   task automatic check_board(input string tag, input logic [N-1:0] want);
      logic [W-1:0] row;
      for (int y = 0; y < H; y++) begin
         read_row(y, row);
         chk($sformatf("%s_row%0d", tag, y), 64'(row), 64'(want[y*W +: W]));
      end
   endtask

   // Issue one command, predict its outcome, then compare when done appears.
   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [8:0] bm,
                          input logic [8:0] sm, input bit hold);
      exp_t        e;
      exp_t        got_e;
      int          a0;
      int          c0;
      bit          seen;
      logic [15:0] l;

      @(negedge clk);
      bus.cmd_op       = op;
      bus.birth_mask   = bm;
      bus.survive_mask = sm;
      bus.cmd_valid    = 1'b1;
      a0 = n_acc;
      @(posedge clk);
      #1;
      if (!hold) bus.cmd_valid = 1'b0;
      c0 = cyc;

      case (op)
         2'd0: begin
            m_board = life_step(m_board, bm, sm);
            m_gen   = m_gen + 1'b1;
            m_pop   = PW'($countones(m_board));
            e.lat   = 10 * N;
         end
         2'd1: begin
            l = m_lfsr;
            for (int i = 0; i < N; i++) begin
               m_board[i] = l[0];
               l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            end
            m_gen = '0;
            m_pop = PW'($countones(m_board));
            e.lat = N;
         end
         2'd2: begin
            m_board = '0;
            m_gen   = '0;
            m_pop   = '0;
            e.lat   = N;
         end
         default: e.lat = 1;
      endcase
      e.gen   = m_gen;
      e.pop   = m_pop;
      e.board = m_board;
      sb_q.push_back(e);

      seen = 1'b0;
      for (int i = 0; i < e.lat + 20 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) seen = 1'b1;
      end
      bus.cmd_valid = 1'b0;

      got_e = sb_q.pop_front();
      chk({tag, "_done_seen"}, 64'(seen), 64'(1));
      chk({tag, "_latency"}, 64'(cyc - c0), 64'(got_e.lat));
      chk({tag, "_accepts"}, 64'(n_acc - a0), 64'(1));
      chk({tag, "_generation"}, 64'(bus.generation), 64'(got_e.gen));
      chk({tag, "_population"}, 64'(bus.population), 64'(got_e.pop));
      chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
      chk({tag, "_ready_at_done"}, 64'(bus.cmd_ready), 64'(0));
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
      chk({tag, "_ready_after"}, 64'(bus.cmd_ready), 64'(1));
      check_board(tag, got_e.board);
   endtask

   initial begin
      reset            = 1'b1;
      bus.cmd_valid    = 1'b0;
      bus.cmd_op       = 2'd3;
      bus.birth_mask   = RULE_B3;
      bus.survive_mask = RULE_S23;
      bus.rd_x         = '0;
      bus.rd_y         = '0;
      m_board          = '0;
      m_gen            = '0;
      m_pop            = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 64'(bus.cmd_ready), 64'(1));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_generation", 64'(bus.generation), 64'(0));
      chk("rst_population", 64'(bus.population), 64'(0));
      @(negedge clk);
      reset = 1'b0;

      // Random fill straight out of reset, then a B36/S23 step while the board is dense.
      run_cmd("rand", 2'd1, 9'b0, 9'b0, 1'b0);
      run_cmd("b36s23", 2'd0, 9'b001001000, RULE_S23, 1'b0);
      // cmd_valid stays high for the whole step: only one acceptance is allowed.
      run_cmd("step_hold", 2'd0, RULE_B3, RULE_S23, 1'b1);
      run_cmd("step2", 2'd0, RULE_B3, RULE_S23, 1'b0);
      run_cmd("nop", 2'd3, 9'b0, 9'b0, 1'b0);

      // Abort a STEP in the middle of cell 1's neighbour reads.
      @(negedge clk);
      bus.cmd_op       = 2'd0;
      bus.birth_mask   = RULE_B3;
      bus.survive_mask = RULE_S23;
      bus.cmd_valid    = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      chk("abort_busy_before", 64'(bus.busy), 64'(1));
      repeat (12) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_ready", 64'(bus.cmd_ready), 64'(1));
      chk("abort_busy", 64'(bus.busy), 64'(0));
      chk("abort_done", 64'(bus.done), 64'(0));
      chk("abort_generation", 64'(bus.generation), 64'(0));
      chk("abort_population", 64'(bus.population), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      m_gen = '0;
      m_pop = '0;
      check_board("abort", m_board);

      run_cmd("clear", 2'd2, 9'b0, 9'b0, 1'b0);
      run_cmd("nop2", 2'd3, 9'b0, 9'b0, 1'b0);
      run_cmd("rand2", 2'd1, 9'b0, 9'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
